// File: rtl/led_fade_pkg.sv
// led_fade_pkg: shared channel state encoding and brightness helpers for led_fade_driver
package led_fade_pkg;
  typedef enum logic [1:0] {OFF, RAMP_UP, ON, RAMP_DOWN} ch_state_e;
  function automatic int pwm_max(input int bits);
    return (1 << bits) - 1;
  endfunction
endpackage

// File: rtl/led_fade_channel.sv
// led_fade_channel: one LED's fade FSM, brightness level and PWM compare
// Define LED_FADE_GAMMA_EN for the square-law duty curve (adds one pipeline stage).
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                target,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led,
  output logic                ramping
);
  localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(pwm_max(PWM_BITS));
  ch_state_e state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic led_q, led_d;
  // A tick always steps in the direction of the current state; a target flip only redirects the next tick.
  always_comb begin
    level_d = level_q;
    state_d = state_q;
    case (state_q)
      OFF: state_d = target ? RAMP_UP : OFF;
      RAMP_UP: begin
        level_d = (tick && level_q != MAX) ? level_q + 1'b1 : level_q;
        state_d = !target ? RAMP_DOWN : (level_d == MAX ? ON : RAMP_UP);
      end
      ON: state_d = target ? ON : RAMP_DOWN;
      default: begin
        level_d = (tick && level_q != '0) ? level_q - 1'b1 : level_q;
        state_d = target ? RAMP_UP : (level_d == '0 ? OFF : RAMP_DOWN);
      end
    endcase
  end
`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic full_q, full_d;
  always_comb begin
    sq = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};
    duty_d = sq[2*PWM_BITS-1:PWM_BITS];
    full_d = level_q == MAX;
    led_d = full_q || pwm_cnt < duty_q;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      duty_q <= '0;
      full_q <= 1'b0;
    end else begin
      duty_q <= duty_d;
      full_q <= full_d;
    end
  end
`else
  always_comb led_d = level_q == MAX || pwm_cnt < level_q;
`endif
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= OFF;
      level_q <= '0;
      led_q <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      led_q <= led_d;
    end
  end
  assign led = led_q;
  assign ramping = state_q == RAMP_UP || state_q == RAMP_DOWN;
endmodule

// File: rtl/led_fade_driver.sv
// led_fade_driver: captures LED targets from the SoC data word and fades each LED via PWM
// Define LED_FADE_GAMMA_EN for square-law brightness (oLed latency becomes 2 cycles).
module led_fade_driver
  import led_fade_pkg::*;
#(
  parameter int LED_COUNT  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIELD_LSB  = 17,
  parameter int PWM_BITS   = 8,
  parameter int FADE_DIV   = 1024
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] iData,
  input  logic                  iValid,
  output logic [LED_COUNT-1:0]  oLed,
  output logic                  oBusy
);
  localparam int PW = FADE_DIV > 1 ? $clog2(FADE_DIV) : 1;
  logic [LED_COUNT-1:0] target_q, target_d, ramping;
  logic [PW-1:0] presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic busy_q, busy_d, tick;
  logic unused_data;
  assign unused_data = ^iData;
  always_comb begin
    tick = presc_q == PW'(FADE_DIV - 1);
    presc_d = tick ? '0 : presc_q + 1'b1;
    pwm_d = pwm_q + 1'b1;
    target_d = iValid ? iData[FIELD_LSB +: LED_COUNT] : target_q;
    busy_d = |ramping;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      target_q <= '0;
      presc_q <= '0;
      pwm_q <= '0;
      busy_q <= 1'b0;
    end else begin
      target_q <= target_d;
      presc_q <= presc_d;
      pwm_q <= pwm_d;
      busy_q <= busy_d;
    end
  end
  for (genvar i = 0; i < LED_COUNT; i++) begin : g_ch
    led_fade_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .Clock(Clock), .Reset(Reset), .target(target_q[i]), .tick(tick),
      .pwm_cnt(pwm_q), .led(oLed[i]), .ramping(ramping[i])
    );
  end
  assign oBusy = busy_q;
endmodule

// File: tb/tb_led_fade_driver.sv
// tb_led_fade_driver: directed self-checking bench for led_fade_driver (PWM_BITS=4, FADE_DIV=2 and 1000)
module tb_led_fade_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] data = '0, pdata = '0;
  logic valid = 1'b0, pvalid = 1'b0;
  logic [3:0] led, pled;
  logic busy, pbusy;
  int checks = 0, failures = 0;

  led_fade_driver #(.LED_COUNT(4), .DATA_WIDTH(32), .FIELD_LSB(17), .PWM_BITS(4), .FADE_DIV(2)) dut (
    .Clock(clk), .Reset(rst), .iData(data), .iValid(valid), .oLed(led), .oBusy(busy)
  );
  led_fade_driver #(.LED_COUNT(4), .DATA_WIDTH(32), .FIELD_LSB(17), .PWM_BITS(4), .FADE_DIV(1000)) dut_p (
    .Clock(clk), .Reset(rst), .iData(pdata), .iValid(pvalid), .oLed(pled), .oBusy(pbusy)
  );

  always #5 clk = ~clk;

  wire [3:0] lvl0 = dut.g_ch[0].u_ch.level_q;
  wire [15:0] lvl_all = {dut.g_ch[3].u_ch.level_q, dut.g_ch[2].u_ch.level_q,
                         dut.g_ch[1].u_ch.level_q, dut.g_ch[0].u_ch.level_q};
  wire [3:0] plvl = dut_p.g_ch[0].u_ch.level_q;

`ifdef LED_FADE_GAMMA_EN
  localparam int DUTY4 = 1, DUTY8 = 4;
`else
  localparam int DUTY4 = 4, DUTY8 = 8;
`endif

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [31:0] d);
    data = d;
    valid = 1'b1;
    step(1);
    valid = 1'b0;
  endtask

  task automatic wait_lvl(input bit pwm_dut, input int v, input int lim, output bit ok);
    int k = 0;
    while ((pwm_dut ? int'(plvl) : int'(lvl0)) != v && k < lim) begin
      step(1);
      k++;
    end
    ok = (pwm_dut ? int'(plvl) : int'(lvl0)) == v;
  endtask

  task automatic count_high(input bit pwm_dut, input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      hi += pwm_dut ? int'(pled[0]) : int'(led[0]);
      step(1);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    data = 32'hFFFF_FFFF;
    valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      checks++;
      if (led !== 4'h0) begin failures++; $display("FAIL reset_led cyc=%0d got=%h exp=0", k, led); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", k, busy); end
    end
    rst = 1'b0;
    valid = 1'b0;
    data = '0;
    step(1);
    checks++;
    if (led !== 4'h0) begin failures++; $display("FAIL post_reset_led got=%h exp=0", led); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_ramp_up;
    bit seen = 0;
    int c = 0, hi;
    capture(32'h1 << 17);
    for (int k = 0; k < 3 && !seen; k++) begin
      step(1);
      c++;
      seen = busy;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL ramp_busy_rise got=0 exp=1 within 2 cycles"); end
    while (busy && c < 80) begin
      step(1);
      c++;
    end
    checks++;
    if (c < 29 || c > 34) begin failures++; $display("FAIL ramp_duration got=%0d exp=29..34", c); end
    step(2);
    count_high(1'b0, 16, hi);
    checks++;
    if (hi != 16) begin failures++; $display("FAIL ramp_on_led got=%0d/16 exp=16/16", hi); end
    checks++;
    if ({busy, led[3:1]} !== 4'h0) begin failures++; $display("FAIL ramp_on_idle got=%b exp=0000", {busy, led[3:1]}); end
  endtask

  task automatic test_reversal;
    bit ok;
    int prev, cur, peak, ups = 0, jumps = 0, t_peak = 0, t_zero = 0, hi;
    capture(32'h0);
    wait_lvl(1'b0, 0, 80, ok);
    step(3);
    capture(32'h1 << 17);
    wait_lvl(1'b0, 7, 40, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rev_reach7 got=%0d exp=7", lvl0); end
    capture(32'h0);
    prev = int'(lvl0);
    peak = prev;
    for (int k = 1; k <= 40 && t_zero == 0; k++) begin
      step(1);
      cur = int'(lvl0);
      if (cur > prev) ups++;
      if (cur < prev - 1) jumps++;
      if (cur > peak) begin peak = cur; t_peak = k; end
      if (cur == 0) t_zero = k;
      prev = cur;
    end
    checks++;
    if (peak != 8) begin failures++; $display("FAIL rev_peak got=%0d exp=8", peak); end
    checks++;
    if (ups != 1 || jumps != 0) begin failures++; $display("FAIL rev_no_jump ups=%0d jumps=%0d exp ups=1 jumps=0", ups, jumps); end
    checks++;
    if (t_zero - t_peak < 15 || t_zero - t_peak > 17) begin
      failures++; $display("FAIL rev_down_time got=%0d exp=15..17", t_zero - t_peak);
    end
    step(3);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rev_off_busy got=%b exp=0", busy); end
    count_high(1'b0, 16, hi);
    checks++;
    if (hi != 0) begin failures++; $display("FAIL rev_off_led got=%0d/16 exp=0/16", hi); end
  endtask

  task automatic test_collision;
    bit ok;
    capture(32'h1 << 17);
    wait_lvl(1'b0, 3, 40, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL col_reach3 got=%0d exp=3", lvl0); end
    step(1);
    data = 32'h0;
    valid = 1'b1;
    step(1);
    valid = 1'b0;
    checks++;
    if (lvl0 !== 4'd4) begin failures++; $display("FAIL col_old_target got=%0d exp=4", lvl0); end
    step(2);
    checks++;
    if (lvl0 !== 4'd3) begin failures++; $display("FAIL col_next_tick got=%0d exp=3", lvl0); end
    wait_lvl(1'b0, 0, 40, ok);
    step(3);
  endtask

  task automatic test_reset_mid;
    bit ok;
    capture(32'hF << 17);
    wait_lvl(1'b0, 10, 40, ok);
    checks++;
    if (lvl_all !== 16'hAAAA) begin failures++; $display("FAIL mid_levels got=%h exp=aaaa", lvl_all); end
    rst = 1'b1;
    step(1);
    checks++;
    if (led !== 4'h0) begin failures++; $display("FAIL mid_reset_led got=%h exp=0", led); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    checks++;
    if (lvl_all !== 16'h0) begin failures++; $display("FAIL mid_reset_levels got=%h exp=0000", lvl_all); end
    data = '0;
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_pwm_duty;
    bit ok;
    int hi;
    pdata = 32'h1 << 17;
    pvalid = 1'b1;
    step(1);
    pvalid = 1'b0;
    wait_lvl(1'b1, 4, 6000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL pwm_reach4 got=%0d exp=4", plvl); end
    step(3);
    count_high(1'b1, 16, hi);
    checks++;
    if (hi != DUTY4) begin failures++; $display("FAIL pwm_duty_l4 got=%0d/16 exp=%0d/16", hi, DUTY4); end
    wait_lvl(1'b1, 8, 6000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL pwm_reach8 got=%0d exp=8", plvl); end
    step(3);
    count_high(1'b1, 16, hi);
    checks++;
    if (hi != DUTY8) begin failures++; $display("FAIL pwm_duty_l8 got=%0d/16 exp=%0d/16", hi, DUTY8); end
  endtask

  initial begin
    step(1);
    test_reset;
    test_ramp_up;
    test_reversal;
    test_collision;
    test_reset_mid;
    test_pwm_duty;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
